alu_sequencer: RTL and testbench

Command-driven initiator for the 8-bit combinational ALU: drives its A, B and select inputs and captures its output into an internal accumulator.
Accepts operation commands over a valid/ready handshake and can repeat an operation N+1 times, for example repeated add as a multiply.
Returns the final accumulator over a second valid/ready handshake.
Sits between the control/command source and the ALU instance.

---
 rtl/alu_sequencer_if.sv | 47 ++++
 rtl/alu_sequencer.sv | 113 +++++++++++
 tb/tb_alu_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Command, ALU and result bundle for alu_sequencer.
// Optional status lines appear when ALU_SEQ_STATUS_EN is defined.
interface alu_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_operand;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [WIDTH-1:0] acc_out;
`ifdef ALU_SEQ_STATUS_EN
  logic             res_zero;
  logic             res_wrap;
`endif

  modport slave (
    input  cmd_valid, cmd_load, cmd_op,
    input  cmd_operand, cmd_count,
    input  alu_out, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel,
`ifdef ALU_SEQ_STATUS_EN
    output res_zero, res_wrap,
`endif
    output res_valid, res_data, acc_out
  );

  modport master (
    output cmd_valid, cmd_load, cmd_op,
    output cmd_operand, cmd_count,
    output alu_out, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel,
`ifdef ALU_SEQ_STATUS_EN
    input  res_zero, res_wrap,
`endif
    input  res_valid, res_data, acc_out
  );
endinterface

// File: rtl/alu_sequencer.sv
// Command-driven ALU initiator with repeat count and accumulator.
// Optional status outputs: define ALU_SEQ_STATUS_EN.
module alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  alu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             rdy;
  logic             accept;
`ifdef ALU_SEQ_STATUS_EN
  logic             wrap_q, wrap_d;
`endif

  assign rdy    = (state_q == IDLE) && rst_n;
  assign accept = bus.cmd_valid && rdy;

  assign bus.cmd_ready = rdy;
  assign bus.alu_a     = acc_q;
  assign bus.alu_b     = opnd_q;
  assign bus.alu_sel   = (state_q == EXEC) ? op_q : 2'b00;
  assign bus.res_valid = (state_q == RESP);
  assign bus.res_data  = acc_q;
  assign bus.acc_out   = acc_q;
`ifdef ALU_SEQ_STATUS_EN
  assign bus.res_zero  = (state_q == RESP) && (acc_q == '0);
  assign bus.res_wrap  = wrap_q;
`endif

  // State, accumulator and latched command registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= 2'b00;
      rem_q   <= '0;
`ifdef ALU_SEQ_STATUS_EN
      wrap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
`ifdef ALU_SEQ_STATUS_EN
      wrap_q  <= wrap_d;
`endif
    end
  end

  // Next-state: accept, repeat captures, then hold result
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    rem_d   = rem_q;
`ifdef ALU_SEQ_STATUS_EN
    wrap_d  = wrap_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_STATUS_EN
          wrap_d = 1'b0;
`endif
          if (bus.cmd_load) begin
            acc_d   = bus.cmd_operand;
            state_d = RESP;
          end else begin
            op_d    = bus.cmd_op;
            opnd_d  = bus.cmd_operand;
            rem_d   = bus.cmd_count;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        acc_d = bus.alu_out;
`ifdef ALU_SEQ_STATUS_EN
        if (op_q == 2'b01 && bus.alu_out < acc_q)
          wrap_d = 1'b1;
        if (op_q == 2'b10 && opnd_q > acc_q)
          wrap_d = 1'b1;
`endif
        if (rem_q != '0)
          rem_d = rem_q - CNT_W'(1);
        else
          state_d = RESP;
      end
      RESP: begin
        if (bus.res_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-bit ALU.
// Status checks compile in when ALU_SEQ_STATUS_EN is defined.
module tb_alu_sequencer;
  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  alu_sequencer_if #(.WIDTH(8), .CNT_W(3)) bus ();

  alu_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU
  always_comb begin
    bus.alu_out = 8'h00;
    case (bus.alu_sel)
      2'b00: bus.alu_out = bus.alu_a;
      2'b01: bus.alu_out = bus.alu_a + bus.alu_b;
      2'b10: bus.alu_out = bus.alu_a - bus.alu_b;
      default: bus.alu_out = 8'h00;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic ld, input logic [1:0] op,
                      input logic [7:0] v, input logic [2:0] cnt);
    bus.cmd_valid   = 1'b1;
    bus.cmd_load    = ld;
    bus.cmd_op      = op;
    bus.cmd_operand = v;
    bus.cmd_count   = cnt;
    step();
    bus.cmd_valid   = 1'b0;
    bus.cmd_load    = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int lat);
    int n;
    n = 0;
    while (!bus.res_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
  endtask

  task automatic take(input string tag);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk({tag, "_vdrop"}, bus.res_valid, 1'b0);
    chk({tag, "_rdy"}, bus.cmd_ready, 1'b1);
  endtask

  task automatic load(input logic [7:0] v);
    send(1'b1, 2'b00, v, 3'd0);
    wait_res("load", 0);
    take("load");
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_load = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_operand = 8'h00;
    bus.cmd_count = 3'd0;
    bus.res_ready = 1'b0;
    step();
    chk("rst_ready", bus.cmd_ready, 1'b0);
    chk("rst_valid", bus.res_valid, 1'b0);
    chk("rst_acc", bus.acc_out, 8'h00);
    chk("rst_sel", bus.alu_sel, 2'b00);
    chk("rst_b", bus.alu_b, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", bus.cmd_ready, 1'b1);

    send(1'b1, 2'b00, 8'h05, 3'd0);
    chk("ld5_valid", bus.res_valid, 1'b1);
    chk("ld5_data", bus.res_data, 8'h05);
    chk("ld5_busy", bus.cmd_ready, 1'b0);
    step();
    chk("ld5_hold", bus.res_valid, 1'b1);
    chk("ld5_busy2", bus.cmd_ready, 1'b0);
    take("ld5");

    send(1'b0, 2'b01, 8'h03, 3'd0);
    wait_res("chain", 1);
    chk("chain_data", bus.res_data, 8'h08);
    take("chain");

    load(8'h00);
    send(1'b0, 2'b01, 8'h07, 3'd3);
    chk("mul_sel", bus.alu_sel, 2'b01);
    chk("mul_b", bus.alu_b, 8'h07);
    chk("mul_busy", bus.cmd_ready, 1'b0);
    wait_res("mul", 4);
    chk("mul_data", bus.res_data, 8'h1C);
    chk("mul_sel_idle", bus.alu_sel, 2'b00);
    take("mul");

    load(8'hFE);
    send(1'b0, 2'b01, 8'h03, 3'd0);
    wait_res("addw", 1);
    chk("addw_data", bus.res_data, 8'h01);
`ifdef ALU_SEQ_STATUS_EN
    chk("addw_wrap", bus.res_wrap, 1'b1);
    chk("addw_zero", bus.res_zero, 1'b0);
`endif
    take("addw");

    load(8'h02);
    send(1'b0, 2'b10, 8'h03, 3'd1);
    wait_res("subw", 2);
    chk("subw_data", bus.res_data, 8'hFC);
`ifdef ALU_SEQ_STATUS_EN
    chk("subw_wrap", bus.res_wrap, 1'b1);
`endif
    take("subw");

    load(8'h10);
    send(1'b0, 2'b01, 8'h01, 3'd1);
    wait_res("nowrap", 2);
    chk("nowrap_data", bus.res_data, 8'h12);
`ifdef ALU_SEQ_STATUS_EN
    chk("nowrap_wrap", bus.res_wrap, 1'b0);
`endif
    take("nowrap");

    load(8'h55);
    send(1'b0, 2'b11, 8'h9A, 3'd5);
    wait_res("clr", 6);
    chk("clr_data", bus.res_data, 8'h00);
`ifdef ALU_SEQ_STATUS_EN
    chk("clr_zero", bus.res_zero, 1'b1);
`endif
    bus.cmd_valid = 1'b1;
    bus.cmd_load = 1'b1;
    bus.cmd_operand = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", bus.res_valid, 1'b1);
      chk("stall_data", bus.res_data, 8'h00);
      chk("stall_ready", bus.cmd_ready, 1'b0);
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_load = 1'b0;
    take("clr");
    chk("clr_acc", bus.acc_out, 8'h00);

    load(8'h10);
    send(1'b0, 2'b01, 8'h01, 3'd7);
    step();
    step();
    chk("mid_acc", bus.acc_out, 8'h12);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_acc", bus.acc_out, 8'h00);
    chk("mid_rst_valid", bus.res_valid, 1'b0);
    chk("mid_rst_ready", bus.cmd_ready, 1'b0);
    chk("mid_rst_sel", bus.alu_sel, 2'b00);
    step();
    rst_n = 1'b1;
    step();
    chk("rel_ready", bus.cmd_ready, 1'b1);
    chk("rel_valid", bus.res_valid, 1'b0);
    chk("rel_acc", bus.acc_out, 8'h00);

    send(1'b0, 2'b01, 8'h04, 3'd0);
    wait_res("post", 1);
    chk("post_data", bus.res_data, 8'h04);
    take("post");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
